// File: rtl/ps2_mem_writer.sv
// PS/2 keyboard receiver that writes each valid scancode into a 16-entry
// memory ring buffer, followed by an update of the write-pointer word.
module ps2_mem_writer #(
  parameter logic [11:0] BASE_ADDR = 12'd1008,
  parameter logic [11:0] PTR_ADDR  = 12'd1007,
  parameter int          TIMEOUT   = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        wEn,
  output logic [11:0] addr,
  output logic [31:0] memDataIn,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WR_DATA, WR_PTR} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    slot_q, slot_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          frame_err_q, frame_err_d;
  logic          wen_q, wen_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          fall, bit_in, fail;

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  always_comb begin
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    clk_prev_d  = clk_s2_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    slot_d      = slot_q;
    seq_d       = seq_q;
    err_count_d = err_count_q;
    frame_err_d = 1'b0;
    wen_d       = 1'b0;
    addr_d      = PTR_ADDR;
    mem_data_d  = 32'd0;
    fail        = 1'b0;

    if (state_q == DATA || state_q == PARITY || state_q == STOP) begin
      to_cnt_d = fall ? '0 : to_cnt_q + TW'(1);
      if (!fall && to_cnt_q == TW'(TIMEOUT - 1)) fail = 1'b1;
    end else begin
      to_cnt_d = '0;
    end

    // Outputs are computed from the transition so they line up with the
    // write states once registered.
    case (state_q)
      IDLE: begin
        if (fall && !bit_in) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (bit_in && (^{shift_q, par_q})) begin
            state_d    = WR_DATA;
            wen_d      = 1'b1;
            addr_d     = BASE_ADDR + {8'd0, slot_q};
            mem_data_d = {16'd0, seq_q, shift_q};
          end else begin
            fail = 1'b1;
          end
        end
      end
      WR_DATA: begin
        state_d    = WR_PTR;
        slot_d     = slot_q + 4'd1;
        seq_d      = seq_q + 8'd1;
        wen_d      = 1'b1;
        addr_d     = PTR_ADDR;
        mem_data_d = {28'd0, slot_q + 4'd1};
      end
      WR_PTR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      slot_q      <= 4'd0;
      seq_q       <= 8'd0;
      err_count_q <= 8'd0;
      frame_err_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= PTR_ADDR;
      mem_data_q  <= 32'd0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      slot_q      <= slot_d;
      seq_q       <= seq_d;
      err_count_q <= err_count_d;
      frame_err_q <= frame_err_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign wEn       = wen_q;
  assign addr      = addr_q;
  assign memDataIn = mem_data_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ps2_mem_writer.sv
// Directed testbench for ps2_mem_writer: drives PS/2 frames and checks the
// memory writes, error pulses and error counter against hand-computed values.
module tb_ps2_mem_writer;

  logic        clk;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic        wEn;
  logic [11:0] addr;
  logic [31:0] memDataIn;
  logic        frame_err;
  logic [7:0]  err_count;

  int vectors;
  int miscompares;
  int half;
  int err_pulses;
  logic [43:0] wr_q[$];

  ps2_mem_writer dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .wEn(wEn), .addr(addr), .memDataIn(memDataIn),
    .frame_err(frame_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write and error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wEn) wr_q.push_back({addr, memDataIn});
    if (frame_err) err_pulses++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_q.delete();
    err_pulses = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (wEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wEn got %b want 0", wEn); end
    vectors++;
    if (addr !== 12'd1007) begin miscompares++; $display("[TB] FAIL reset_addr got %0d want 1007", addr); end
    vectors++;
    if (memDataIn !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", memDataIn); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_err got %b want 0", frame_err); end
    vectors++;
    if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_q.delete();
    err_pulses = 0;
  endtask

  // Frame 0x1C with cycle-exact latency check around the stop-bit edge.
  task automatic test_basic();
    logic [7:0] d;
    d = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (wEn !== 1'b0) begin miscompares++; $display("[TB] FAIL early_wEn got %b want 0", wEn); end
    @(negedge clk);
    vectors++;
    if ({wEn, addr, memDataIn} !== {1'b1, 12'd1008, 32'h0000001C}) begin
      miscompares++;
      $display("[TB] FAIL wr_data got wEn=%b addr=%0d data=%h want 1/1008/0000001c", wEn, addr, memDataIn);
    end
    @(negedge clk);
    vectors++;
    if ({wEn, addr, memDataIn} !== {1'b1, 12'd1007, 32'h00000001}) begin
      miscompares++;
      $display("[TB] FAIL wr_ptr got wEn=%b addr=%0d data=%h want 1/1007/00000001", wEn, addr, memDataIn);
    end
    @(negedge clk);
    vectors++;
    if ({wEn, addr, memDataIn} !== {1'b0, 12'd1007, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL post_write got wEn=%b addr=%0d data=%h want 0/1007/0", wEn, addr, memDataIn);
    end
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (wr_q.size() != 2 || err_pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_counts got writes=%0d errs=%0d want 2/0", wr_q.size(), err_pulses);
    end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
    vectors++;
    if (wr_q.size() != 0) begin miscompares++; $display("[TB] FAIL parity_writes got %0d want 0", wr_q.size()); end
    vectors++;
    if (err_pulses != 1) begin miscompares++; $display("[TB] FAIL parity_pulses got %0d want 1", err_pulses); end
    vectors++;
    if (err_count !== 8'd1) begin miscompares++; $display("[TB] FAIL parity_err_count got %0d want 1", err_count); end
  endtask

  task automatic test_bad_stop();
    send_frame(8'h1C, 1'b0, 1'b0);
    vectors++;
    if (wr_q.size() != 0) begin miscompares++; $display("[TB] FAIL stop_writes got %0d want 0", wr_q.size()); end
    vectors++;
    if (err_count !== 8'd2 || err_pulses != 2) begin
      miscompares++;
      $display("[TB] FAIL stop_err got count=%0d pulses=%0d want 2/2", err_count, err_pulses);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (20000 - 100) @(negedge clk);
    vectors++;
    if (err_pulses != 0) begin miscompares++; $display("[TB] FAIL timeout_early got pulses=%0d want 0", err_pulses); end
    repeat (200) @(negedge clk);
    vectors++;
    if (err_pulses != 1 || err_count !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL timeout_err got pulses=%0d count=%0d want 1/1", err_pulses, err_count);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    vectors++;
    if (wr_q.size() != 2 || wr_q[0] !== {12'd1008, 32'h0000001C} || wr_q[1] !== {12'd1007, 32'h00000001}) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover got n=%0d w0=%h want 2/3f00000001c", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 44'h0);
    end
  endtask

  task automatic test_wrap();
    logic [43:0] exp;
    do_reset();
    for (int k = 0; k < 17; k++) send_frame(8'(k), 1'b0, 1'b1);
    vectors++;
    if (wr_q.size() != 34) begin miscompares++; $display("[TB] FAIL wrap_count got %0d want 34", wr_q.size()); end
    if (wr_q.size() == 34) begin
      for (int k = 0; k < 16; k++) begin
        exp = {12'd1008 + 12'(k), 16'd0, 8'(k), 8'(k)};
        vectors++;
        if (wr_q[2*k] !== exp) begin
          miscompares++;
          $display("[TB] FAIL wrap_slot%0d got %h want %h", k, wr_q[2*k], exp);
        end
      end
      vectors++;
      if (wr_q[31] !== {12'd1007, 32'h00000000}) begin
        miscompares++;
        $display("[TB] FAIL wrap_ptr16 got %h want 3ef00000000", wr_q[31]);
      end
      vectors++;
      if (wr_q[32] !== {12'd1008, 32'h00001010}) begin
        miscompares++;
        $display("[TB] FAIL wrap_write17 got %h want 3f000001010", wr_q[32]);
      end
      vectors++;
      if (wr_q[33] !== {12'd1007, 32'h00000001}) begin
        miscompares++;
        $display("[TB] FAIL wrap_ptr17 got %h want 3ef00000001", wr_q[33]);
      end
    end
  endtask

  task automatic test_saturate();
    half = 4;
    do_reset();
    for (int k = 0; k < 254; k++) send_frame(8'h55, 1'b0, 1'b0);
    vectors++;
    if (err_count !== 8'd254) begin miscompares++; $display("[TB] FAIL sat_254 got %0d want 254", err_count); end
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    vectors++;
    if (err_count !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_hold got %0d want 255", err_count); end
    vectors++;
    if (err_pulses != 256) begin miscompares++; $display("[TB] FAIL sat_pulses got %0d want 256", err_pulses); end
    half = 10;
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h21, 1'b0, 1'b1);
    wr_q.delete();
    err_pulses = 0;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (wr_q.size() != 0 || err_pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet got writes=%0d pulses=%0d want 0/0", wr_q.size(), err_pulses);
    end
    vectors++;
    if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL midreset_err_count got %0d want 0", err_count); end
    send_frame(8'h1C, 1'b0, 1'b1);
    vectors++;
    if (wr_q.size() != 2 || wr_q[0] !== {12'd1008, 32'h0000001C}) begin
      miscompares++;
      $display("[TB] FAIL midreset_write got n=%0d w0=%h want 2/3f00000001c", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 44'h0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_pulses  = 0;
    half        = 10;
    reset_n     = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    test_reset();
    test_basic();
    test_bad_parity();
    test_bad_stop();
    test_timeout();
    test_wrap();
    test_saturate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
